// File: rtl/gd_update_ctrl.sv
// gd_update_ctrl
//   Sequencer for a fixed-point gradient-descent loop. It launches an external
//   gradient stage with the current x, waits for its result, applies
//   x <- x - x_diff with saturation, and stops on convergence
//   (|gradient| <= GRAD_TOL), on the iteration limit, on a stage overflow, or
//   when the stage fails to answer within WAIT_TIMEOUT cycles.
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   start             : begin a run (only looked at while idle)
//   func_done         : gradient stage result valid (consumed once per launch)
//   x_diff            : Q24.8 signed step from the stage
//   gradient, value   : Q56.8 signed gradient and f(x) from the stage
//   func_ovf          : stage overflow flag, captured with the result
//   start_func        : one-cycle launch pulse to the stage
//   x_out             : current x (Q24.8), stable while the stage works
//   best_value        : most recently captured f(x)
//   iter_count        : completed iterations in this run
//   busy              : high whenever the controller is not idle
//   done              : one-cycle end-of-run pulse
//   converged, error  : run outcome flags
//   sat               : sticky, an applied x update was clamped this run
module gd_update_ctrl #(
  parameter logic [31:0] X_INIT       = 32'h00000A00,
  parameter logic [15:0] MAX_ITER     = 16'd1000,
  parameter logic [63:0] GRAD_TOL     = 64'h0000000000000004,
  parameter logic [15:0] WAIT_TIMEOUT = 16'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        func_done,
  input  logic [31:0] x_diff,
  input  logic [63:0] gradient,
  input  logic [63:0] value,
  input  logic        func_ovf,
  output logic        start_func,
  output logic [31:0] x_out,
  output logic [63:0] best_value,
  output logic [15:0] iter_count,
  output logic        busy,
  output logic        done,
  output logic        converged,
  output logic        error,
  output logic        sat
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_UPDATE = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [63:0] GRAD_MIN = 64'h8000000000000000;
  localparam logic [63:0] GRAD_MAX = 64'h7FFFFFFFFFFFFFFF;
  localparam logic [31:0] X_MAX    = 32'h7FFFFFFF;
  localparam logic [31:0] X_MIN    = 32'h80000000;

  // Magnitude of a two's-complement value; the most negative code has no
  // positive counterpart, so it maps to the largest positive code.
  function automatic logic [63:0] abs_sat(input logic [63:0] v);
    logic [63:0] r;
    if (v == GRAD_MIN) begin
      r = GRAD_MAX;
    end else if (v[63] == 1'b1) begin
      r = ~v + 64'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t      r_state;
  logic [15:0] r_wait_cnt;
  logic [31:0] r_x_diff;
  logic [63:0] r_grad;
  logic [63:0] r_value;
  logic        r_ovf;

  logic        r_start_func;
  logic [31:0] r_x_out;
  logic [63:0] r_best_value;
  logic [15:0] r_iter_count;
  logic        r_busy;
  logic        r_done;
  logic        r_converged;
  logic        r_error;
  logic        r_sat;

  logic [32:0] w_x_wide;
  logic [31:0] w_x_next;
  logic        w_x_clamped;
  logic [63:0] w_grad_abs;
  logic        w_grad_small;
  logic [15:0] w_iter_next;
  logic        w_last_iter;
  logic [15:0] w_wait_next;
  logic        w_timeout;

  // Sign-extend both operands by one bit so the subtraction cannot wrap.
  assign w_x_wide     = {r_x_out[31], r_x_out} - {r_x_diff[31], r_x_diff};
  assign w_grad_abs   = abs_sat(r_grad);
  assign w_grad_small = (w_grad_abs <= GRAD_TOL);
  assign w_iter_next  = r_iter_count + 16'd1;
  assign w_last_iter  = (w_iter_next == MAX_ITER);
  assign w_wait_next  = r_wait_cnt + 16'd1;
  assign w_timeout    = (w_wait_next >= WAIT_TIMEOUT);

  // Clamp the 33-bit difference into the Q24.8 range; the top two bits
  // disagree exactly when the result left the 32-bit signed range.
  always_comb begin
    w_x_next    = w_x_wide[31:0];
    w_x_clamped = 1'b0;
    if ((w_x_wide[32] == 1'b0) && (w_x_wide[31] == 1'b1)) begin
      w_x_next    = X_MAX;
      w_x_clamped = 1'b1;
    end else if ((w_x_wide[32] == 1'b1) && (w_x_wide[31] == 1'b0)) begin
      w_x_next    = X_MIN;
      w_x_clamped = 1'b1;
    end else begin
      w_x_next    = w_x_wide[31:0];
      w_x_clamped = 1'b0;
    end
  end

  // Control FSM together with every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= 16'd0;
      r_x_diff     <= 32'd0;
      r_grad       <= 64'd0;
      r_value      <= 64'd0;
      r_ovf        <= 1'b0;
      r_start_func <= 1'b0;
      r_x_out      <= X_INIT;
      r_best_value <= 64'd0;
      r_iter_count <= 16'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_converged  <= 1'b0;
      r_error      <= 1'b0;
      r_sat        <= 1'b0;
    end else begin
      // Pulse outputs are asserted only by the transition that needs them.
      r_start_func <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x_out      <= X_INIT;
            r_iter_count <= 16'd0;
            r_converged  <= 1'b0;
            r_error      <= 1'b0;
            r_sat        <= 1'b0;
            r_best_value <= 64'd0;
            r_busy       <= 1'b1;
            r_start_func <= 1'b1;
            r_state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_wait_cnt <= 16'd0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          // Leaving WAIT on the first func_done means a level held high
          // for several cycles is only consumed once.
          if (func_done) begin
            r_x_diff <= x_diff;
            r_grad   <= gradient;
            r_value  <= value;
            r_ovf    <= func_ovf;
            r_state  <= S_UPDATE;
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_wait_cnt <= w_wait_next;
          end
        end
        S_UPDATE: begin
          r_best_value <= r_value;
          r_iter_count <= w_iter_next;
          if (r_ovf) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end else if (w_grad_small) begin
            r_converged <= 1'b1;
            r_done      <= 1'b1;
            r_state     <= S_FINISH;
          end else begin
            // sat only reflects updates that were actually applied to x.
            r_x_out <= w_x_next;
            r_sat   <= r_sat | w_x_clamped;
            if (w_last_iter) begin
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_start_func <= 1'b1;
              r_state      <= S_LAUNCH;
            end
          end
        end
        S_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign start_func = r_start_func;
  assign x_out      = r_x_out;
  assign best_value = r_best_value;
  assign iter_count = r_iter_count;
  assign busy       = r_busy;
  assign done       = r_done;
  assign converged  = r_converged;
  assign error      = r_error;
  assign sat        = r_sat;

endmodule

// File: tb/tb_gd_update_ctrl.sv
// Scoreboard bench for gd_update_ctrl. Three instances with different
// parameters share the stage-side inputs; only the selected one is started.
module tb_gd_update_ctrl;

  localparam int M_MAN = 0, M_SQ = 1, M_CONST = 2, M_OVF = 3, M_TO = 4, M_SAT = 5, M_RAND = 6;
  localparam int LAT = 4;
  localparam logic [63:0] TOL = 64'd4;
  localparam longint XMAX = 64'sd2147483647;
  localparam longint XMIN = -64'sd2147483648;

  typedef struct {
    logic [31:0] x;
    logic [63:0] best;
    logic [15:0] iter;
    logic        conv;
    logic        err;
    logic        sat;
    int          launches;
  } exp_t;

  logic clk, rst;
  logic start_v [3];
  logic func_done, model_done, man_done, func_ovf;
  logic [31:0] x_diff;
  logic [63:0] gradient, value;
  logic        sf_v [3], busy_v [3], done_v [3], conv_v [3], err_v [3], sat_v [3];
  logic [31:0] xo_v [3];
  logic [63:0] best_v [3];
  logic [15:0] it_v [3];

  logic sf_m, busy_m, done_m, conv_m, err_m, sat_m;
  logic [31:0] xo_m;
  logic [63:0] best_m;
  logic [15:0] it_m;

  int sel, mode, hold_len, run_id, launches, resp_idx;
  int n_checks, n_err;
  exp_t exp_q [$];
  logic [31:0] t_xd [4];
  logic [63:0] t_gr [4];
  logic [63:0] t_val [4];
  logic        t_ovf [4];

  assign func_done = (mode == M_MAN) ? man_done : model_done;

  gd_update_ctrl #(.X_INIT(32'h00000A00), .MAX_ITER(16'd1000), .GRAD_TOL(64'd4), .WAIT_TIMEOUT(16'd8)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .func_done(func_done), .x_diff(x_diff),
    .gradient(gradient), .value(value), .func_ovf(func_ovf), .start_func(sf_v[0]),
    .x_out(xo_v[0]), .best_value(best_v[0]), .iter_count(it_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .converged(conv_v[0]), .error(err_v[0]), .sat(sat_v[0]));

  gd_update_ctrl #(.X_INIT(32'h00000A00), .MAX_ITER(16'd3), .GRAD_TOL(64'd4), .WAIT_TIMEOUT(16'd8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .func_done(func_done), .x_diff(x_diff),
    .gradient(gradient), .value(value), .func_ovf(func_ovf), .start_func(sf_v[1]),
    .x_out(xo_v[1]), .best_value(best_v[1]), .iter_count(it_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .converged(conv_v[1]), .error(err_v[1]), .sat(sat_v[1]));

  gd_update_ctrl #(.X_INIT(32'h80000100), .MAX_ITER(16'd3), .GRAD_TOL(64'd4), .WAIT_TIMEOUT(16'd8)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .func_done(func_done), .x_diff(x_diff),
    .gradient(gradient), .value(value), .func_ovf(func_ovf), .start_func(sf_v[2]),
    .x_out(xo_v[2]), .best_value(best_v[2]), .iter_count(it_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .converged(conv_v[2]), .error(err_v[2]), .sat(sat_v[2]));

  // View of the instance currently under test.
  always_comb begin
    sf_m   = sf_v[sel];
    busy_m = busy_v[sel];
    done_m = done_v[sel];
    conv_m = conv_v[sel];
    err_m  = err_v[sel];
    sat_m  = sat_v[sel];
    xo_m   = xo_v[sel];
    best_m = best_v[sel];
    it_m   = it_v[sel];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] xinit_of(input int s);
    return (s == 2) ? 32'h80000100 : 32'h00000A00;
  endfunction

  function automatic int maxit_of(input int s);
    return (s == 0) ? 1000 : 3;
  endfunction

  function automatic logic [63:0] mag(input logic [63:0] g);
    if (g == 64'h8000000000000000) return 64'h7FFFFFFFFFFFFFFF;
    else if ($signed(g) < 0) return 64'd0 - g;
    else return g;
  endfunction

  // Gradient stage behaviour: f = x^2 with step x/2, or a prepared table.
  function automatic void get_resp(input int m, input int idx, input logic [31:0] x,
                                   output logic [31:0] xd, output logic [63:0] g,
                                   output logic [63:0] v, output logic o);
    if (m == M_SQ) begin
      g  = 64'(64'sd2 * longint'($signed(x)));
      xd = 32'($signed(x) / 32'sd2);
      v  = 64'((longint'($signed(x)) * longint'($signed(x))) >>> 8);
      o  = 1'b0;
    end else begin
      xd = t_xd[idx & 3];
      g  = t_gr[idx & 3];
      v  = t_val[idx & 3];
      o  = t_ovf[idx & 3];
    end
  endfunction

  // Whole-run outcome from the descent rules, iterated in plain arithmetic.
  function automatic exp_t ref_run(input int s, input int m);
    exp_t e;
    logic [31:0] x, xd;
    logic [63:0] g, v;
    logic o;
    longint xn;
    x = xinit_of(s);
    e.x = x; e.best = 64'd0; e.iter = 16'd0; e.conv = 1'b0; e.err = 1'b0; e.sat = 1'b0; e.launches = 0;
    for (int k = 0; k < 70000; k++) begin
      e.launches++;
      if (m == M_TO) begin e.err = 1'b1; break; end
      get_resp(m, k, x, xd, g, v, o);
      e.best = v;
      e.iter = e.iter + 16'd1;
      if (o) begin e.err = 1'b1; break; end
      if (mag(g) <= TOL) begin e.conv = 1'b1; break; end
      xn = longint'($signed(x)) - longint'($signed(xd));
      if (xn > XMAX) begin xn = XMAX; e.sat = 1'b1; end
      else if (xn < XMIN) begin xn = XMIN; e.sat = 1'b1; end
      x = 32'(xn);
      e.x = x;
      if (int'(e.iter) == maxit_of(s)) break;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: actual %h required %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic fill_tables(input int m);
    int r;
    for (int i = 0; i < 4; i++) begin
      if (m == M_RAND) begin
        r = $urandom_range(0, 9);
        case (r)
          0: t_gr[i] = 64'd4;
          1: t_gr[i] = 64'd0 - 64'd4;
          2: t_gr[i] = 64'd5;
          3: t_gr[i] = 64'd0 - 64'd5;
          4: t_gr[i] = 64'h8000000000000000;
          5: t_gr[i] = 64'd0;
          default: t_gr[i] = {$urandom, $urandom};
        endcase
        t_xd[i]  = $urandom;
        t_val[i] = {$urandom, $urandom};
        t_ovf[i] = ($urandom_range(0, 5) == 0);
        if (t_ovf[i] || (mag(t_gr[i]) <= TOL)) t_xd[i] = 32'd0;
      end else begin
        t_gr[i]  = 64'h1000;
        t_xd[i]  = (m == M_SAT) ? 32'h00000200 : 32'h00000100;
        t_val[i] = 64'h1234 + 64'(i);
        t_ovf[i] = (m == M_OVF) && (i == 1);
      end
    end
  endtask

  // Gradient stage model: answers each start_func after LAT cycles.
  initial begin : grad_stage
    int cnt, hold_left, seen_run;
    logic [31:0] cap_x, xd;
    logic [63:0] g, v;
    logic o;
    cnt = 0; hold_left = 0; seen_run = -1; cap_x = 32'd0;
    model_done = 1'b0; x_diff = 32'd0; gradient = 64'd0; value = 64'd0; func_ovf = 1'b0;
    launches = 0; resp_idx = 0;
    forever begin
      @(negedge clk);
      if (seen_run != run_id) begin
        seen_run = run_id; launches = 0; resp_idx = 0; cnt = 0;
      end
      if (rst) begin
        cnt = 0; hold_left = 0; model_done = 1'b0;
      end else begin
        if (hold_left > 0) begin
          hold_left--;
          if (hold_left == 0) model_done = 1'b0;
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            chk("x_stable_during_stage", 64'(xo_m), 64'(cap_x));
            get_resp(mode, resp_idx, cap_x, xd, g, v, o);
            x_diff = xd; gradient = g; value = v; func_ovf = o;
            model_done = 1'b1; hold_left = hold_len; resp_idx++;
          end
        end
        if (sf_m) begin
          launches++;
          if (mode == M_SQ && launches > 1)
            chk("x_toward_zero", 64'(($signed(xo_m) < $signed(cap_x)) && ($signed(xo_m) >= 0)), 64'd1);
          cap_x = xo_m;
          if (mode != M_TO && mode != M_MAN) cnt = LAT;
        end
      end
    end
  end

  // Monitor: every done pulse of the instance under test pops one expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done_m) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'(done_m), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("x_out", 64'(xo_m), 64'(e.x));
          chk("best_value", best_m, e.best);
          chk("iter_count", 64'(it_m), 64'(e.iter));
          chk("converged", 64'(conv_m), 64'(e.conv));
          chk("error", 64'(err_m), 64'(e.err));
          chk("sat", 64'(sat_m), 64'(e.sat));
          chk("launch_count", 64'(launches), 64'(e.launches));
          chk("busy_at_done", 64'(busy_m), 64'd1);
        end
      end
    end
  end

  task automatic check_reset(input int s);
    chk("rst_x_out", 64'(xo_v[s]), 64'(xinit_of(s)));
    chk("rst_best", best_v[s], 64'd0);
    chk("rst_iter", 64'(it_v[s]), 64'd0);
    chk("rst_flags", 64'({sf_v[s], busy_v[s], done_v[s], conv_v[s], err_v[s], sat_v[s]}), 64'd0);
  endtask

  task automatic run(input int s, input int m, input int hold);
    exp_t e;
    int c;
    sel = s; mode = m; hold_len = hold; run_id++;
    fill_tables(m);
    e = ref_run(s, m);
    exp_q.push_back(e);
    @(negedge clk); start_v[s] = 1'b1;
    @(negedge clk); start_v[s] = 1'b0;
    repeat (5) @(negedge clk);
    // A start while busy must not disturb the run.
    if (busy_m) begin
      start_v[s] = 1'b1;
      @(negedge clk); start_v[s] = 1'b0;
    end
    c = 0;
    while (exp_q.size() != 0 && c < 5000) begin
      @(negedge clk); c++;
    end
    chk("run_completed", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (4) @(negedge clk);
    chk("hold_x_out", 64'(xo_m), 64'(e.x));
    chk("hold_iter", 64'(it_m), 64'(e.iter));
    chk("hold_best", best_m, e.best);
    chk("hold_flags", 64'({busy_m, conv_m, err_m, sat_m}), 64'({1'b0, e.conv, e.err, e.sat}));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual still running, required finished");
    $fatal(1);
  end

  initial begin : stim
    int c;
    n_checks = 0; n_err = 0;
    sel = 0; mode = M_MAN; hold_len = 1; run_id = 0; man_done = 1'b0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    for (int i = 0; i < 4; i++) begin t_xd[i] = 32'd0; t_gr[i] = 64'd0; t_val[i] = 64'd0; t_ovf[i] = 1'b0; end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) check_reset(s);
    rst = 1'b0;

    run(0, M_SQ, 1);      // f = x^2 descent to convergence
    run(1, M_CONST, 1);   // iteration limit: 0xA00 - 3*0x100 = 0x700
    run(1, M_OVF, 1);     // overflow on iteration 2
    run(0, M_TO, 1);      // stage never answers
    run(2, M_SAT, 1);     // negative saturation

    // Reset while waiting, with func_done held through and past the reset.
    sel = 0; mode = M_MAN; run_id++;
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    c = 0;
    while (!sf_m && c < 20) begin @(negedge clk); c++; end
    chk("manual_launch_seen", 64'(sf_m), 64'd1);
    repeat (2) @(negedge clk);
    chk("manual_in_wait", 64'({busy_m, sf_m}), 64'({1'b1, 1'b0}));
    rst = 1'b1; man_done = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
    check_reset(0);
    chk("manual_single_launch", 64'(launches), 64'd1);

    run(0, M_SQ, 3);      // clean restart, func_done held 3 cycles each time

    for (int r = 0; r < 20; r++) run(1 + int'($urandom_range(0, 1)), M_RAND, int'($urandom_range(1, 3)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
